// File: rtl/cmp_search.sv
// cmp_search: initiator side of an lt/eq/gt magnitude-compare handshake.
// Runs a successive-approximation search for the comparator's hidden operand.
// The optional per-probe timeout is enabled by defining CMP_TIMEOUT_EN.
module cmp_search #(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] probe,
  output logic         probe_valid,
  input  logic         cmp_valid,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         error,
  output logic [W-1:0] result,
  output logic [3:0]   steps
);

  typedef enum logic [1:0] {IDLE, PROBE, SETTLE, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] lo, hi;
  logic [W-1:0] lo_nxt, hi_nxt, result_nxt;
  logic         found_nxt, error_nxt;
  logic [3:0]   steps_nxt;
  logic [W:0]   sum;
  logic         verdict_ok;

`ifdef CMP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;
`endif

  // One extra bit keeps lo+hi exact before halving.
  assign sum         = {1'b0, lo} + {1'b0, hi};
  assign probe       = sum[W:1];
  assign probe_valid = (state == PROBE);
  assign busy        = (state == PROBE) || (state == SETTLE);
  assign done        = (state == DONE);
  assign verdict_ok  = $onehot({cmp_lt, cmp_eq, cmp_gt});

`ifdef CMP_TIMEOUT_EN
  assign timed_out = (wait_cnt == TW'(TIMEOUT - 1));

  // Per-probe wait counter; cleared whenever the FSM is not waiting in PROBE.
  always_ff @(posedge clk) begin
    if (rst || state != PROBE || cmp_valid) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Search window and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo     <= '0;
      hi     <= '1;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      steps  <= '0;
    end else begin
      lo     <= lo_nxt;
      hi     <= hi_nxt;
      found  <= found_nxt;
      error  <= error_nxt;
      result <= result_nxt;
      steps  <= steps_nxt;
    end
  end

  // Next-state and verdict decode; the probe==hi / probe==lo guards keep lo/hi in range.
  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    found_nxt  = found;
    error_nxt  = error;
    result_nxt = result;
    steps_nxt  = steps;
    case (state)
      IDLE: begin
        if (start) begin
          lo_nxt     = '0;
          hi_nxt     = '1;
          found_nxt  = 1'b0;
          error_nxt  = 1'b0;
          result_nxt = '0;
          steps_nxt  = '0;
          state_nxt  = PROBE;
        end
      end
      PROBE: begin
        if (cmp_valid) begin
          steps_nxt = steps + 4'd1;
          state_nxt = DONE;
          if (!verdict_ok) begin
            error_nxt = 1'b1;
          end else if (cmp_eq) begin
            result_nxt = probe;
            found_nxt  = 1'b1;
          end else if (cmp_lt) begin
            if (probe == hi) begin
              error_nxt = 1'b1;
            end else begin
              lo_nxt    = probe + W'(1);
              state_nxt = SETTLE;
            end
          end else begin
            if (probe == lo) begin
              error_nxt = 1'b1;
            end else begin
              hi_nxt    = probe - W'(1);
              state_nxt = SETTLE;
            end
          end
        end
`ifdef CMP_TIMEOUT_EN
        else if (timed_out) begin
          error_nxt = 1'b1;
          found_nxt = 1'b0;
          state_nxt = DONE;
        end
`endif
      end
      SETTLE: begin
        state_nxt = PROBE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmp_search.sv
// tb_cmp_search: directed, table-driven bench for cmp_search (W=4).
module tb_cmp_search;

  localparam int unsigned W = 4;

  typedef enum int {M_HONEST, M_LT, M_GT, M_BOTH, M_NONE, M_NEVER} mode_t;

  typedef struct {
    mode_t      mode;
    logic [3:0] y;
    logic       fnd;
    logic       err;
    logic [3:0] res;
    logic [3:0] stp;
    int         lat;
    int         np;
    logic [3:0] pr [6];
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         cmp_valid, cmp_lt, cmp_eq, cmp_gt;
  logic         busy, done, found, error;
  logic [W-1:0] result;
  logic [3:0]   steps;

  mode_t      mode = M_HONEST;
  logic [3:0] y = '0;
  int         delay = 0;
  logic       force_valid = 1'b0;
  int         wcnt = 0;
  logic [3:0] plog [$];
  int         checks = 0;
  int         errors = 0;

  vec_t       vecs [9];
  vec_t       v9;
  vec_t       vto;
  logic [3:0] dexp [3];

  cmp_search #(.W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe), .probe_valid(probe_valid),
    .cmp_valid(cmp_valid), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .found(found), .error(error), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  // Cycles the current probe has been waiting.
  always @(posedge clk) wcnt <= probe_valid ? wcnt + 1 : 0;

  // Comparator model with selectable misbehaviour.
  always_comb begin
    cmp_valid = force_valid || (probe_valid && mode != M_NEVER && wcnt >= delay);
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    cmp_gt = 1'b0;
    case (mode)
      M_HONEST: begin
        cmp_lt = probe < y;
        cmp_eq = probe == y;
        cmp_gt = probe > y;
      end
      M_LT:   cmp_lt = 1'b1;
      M_GT:   cmp_gt = 1'b1;
      M_BOTH: begin cmp_lt = 1'b1; cmp_gt = 1'b1; end
      default: ;
    endcase
  end

  // Log every probe value that receives an accepted verdict.
  always @(negedge clk) if (probe_valid && cmp_valid) plog.push_back(probe);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_probe_valid"}, probe_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_steps"}, steps, 0);
  endtask

  task automatic run_check(input string tag, input vec_t v);
    int cyc;
    mode = v.mode;
    y = v.y;
    delay = 0;
    plog.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin
      tick;
      cyc++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cyc + 1, v.lat);
    chk({tag, "_found"}, found, v.fnd);
    chk({tag, "_error"}, error, v.err);
    chk({tag, "_result"}, result, v.res);
    chk({tag, "_steps"}, steps, v.stp);
    chk({tag, "_nprobes"}, plog.size(), v.np);
    for (int i = 0; i < v.np; i++) begin
      if (i < plog.size()) chk($sformatf("%s_probe%0d", tag, i), plog[i], v.pr[i]);
    end
    tick;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_steps_held"}, steps, v.stp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int dseen;
    int lows;

    vecs[0] = '{M_HONEST, 4'd11, 1'b1, 1'b0, 4'd11, 4'd2, 5, 2, '{4'd7, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[1] = '{M_HONEST, 4'd0, 1'b1, 1'b0, 4'd0, 4'd4, 9, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0}};
    vecs[2] = '{M_HONEST, 4'd15, 1'b1, 1'b0, 4'd15, 4'd5, 11, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0}};
    vecs[3] = '{M_HONEST, 4'd7, 1'b1, 1'b0, 4'd7, 4'd1, 3, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[4] = '{M_HONEST, 4'd14, 1'b1, 1'b0, 4'd14, 4'd4, 9, 4, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd0, 4'd0}};
    vecs[5] = '{M_LT, 4'd0, 1'b0, 1'b1, 4'd0, 4'd5, 11, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0}};
    vecs[6] = '{M_GT, 4'd0, 1'b0, 1'b1, 4'd0, 4'd4, 9, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0}};
    vecs[7] = '{M_BOTH, 4'd0, 1'b0, 1'b1, 4'd0, 4'd1, 3, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[8] = '{M_NONE, 4'd0, 1'b0, 1'b1, 4'd0, 4'd1, 3, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    v9      = '{M_HONEST, 4'd9, 1'b1, 1'b0, 4'd9, 4'd3, 7, 3, '{4'd7, 4'd11, 4'd9, 4'd0, 4'd0, 4'd0}};
    vto     = '{M_NEVER, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 17, 0, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    dexp    = '{4'd7, 4'd3, 4'd5};

    // Reset state.
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk_reset_state("reset");

    // Table of zero-wait searches.
    for (int i = 0; i < 9; i++) run_check($sformatf("vec%0d", i), vecs[i]);

    // Slow comparator (3 wait cycles), y=5, with stray cmp_valid pulses in SETTLE.
    mode = M_HONEST;
    y = 4'd5;
    delay = 3;
    plog.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      force_valid = (c == 5 || c == 10);
      chk($sformatf("slow_pv_c%0d", c), probe_valid, (c % 5) != 0);
      if ((c % 5) != 0) chk($sformatf("slow_probe_c%0d", c), probe, dexp[(c - 1) / 5]);
      tick;
    end
    force_valid = 1'b0;
    chk("slow_done", done, 1);
    chk("slow_found", found, 1);
    chk("slow_result", result, 5);
    chk("slow_steps", steps, 3);

    // Stray cmp_valid in IDLE is ignored.
    tick;
    mode = M_LT;
    force_valid = 1'b1;
    tick;
    force_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_pv", probe_valid, 0);
    chk("idle_done", done, 0);
    chk("idle_steps", steps, 3);
    chk("idle_found", found, 1);

    // Reset during the second probe.
    mode = M_HONEST;
    y = 4'd9;
    delay = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("midrst_pv", probe_valid, 1);
    chk("midrst_probe", probe, 11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_reset_state("midrst");
    dseen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) dseen++;
      tick;
    end
    chk("midrst_no_done", dseen, 0);
    run_check("after_rst", v9);

    // Comparator that never answers.
`ifdef CMP_TIMEOUT_EN
    run_check("timeout", vto);
`else
    mode = M_NEVER;
    start = 1'b1;
    tick;
    start = 1'b0;
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy !== 1'b1) lows++;
      tick;
    end
    chk("nevervalid_busy_low_cycles", lows, 0);
    chk("nevervalid_no_error", error, vto.stp);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_reset_state("final_rst");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_search.md
Name: cmp_search

Overview:
- Initiator side of the lt/eq/gt magnitude-compare interface. It drives probe values into an external W-bit comparator and consumes its lt/eq/gt verdicts.
- Runs a binary (successive-approximation) search that locates the comparator's hidden operand y in at most W+1 probes.
- Sits between a control FSM (start/done) and any compare unit, combinational or registered, via a valid/valid handshake.

Parameters:
- W, 4, operand width; legal range 1..14.
- TIMEOUT, 15, max cycles to wait for cmp_valid per probe; used only with CMP_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- probe  out  W  candidate x = floor((lo+hi)/2), from the lo/hi registers.
- probe_valid  out  1  probe is stable and awaits a verdict.
- cmp_valid  in  1  lt/eq/gt are valid this cycle.
- cmp_lt  in  1  probe < y.
- cmp_eq  in  1  probe == y.
- cmp_gt  in  1  probe > y.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse at end of search.
- found  out  1  result holds y; valid from done until the next start.
- error  out  1  search aborted (inconsistent or invalid verdict, or timeout).
- result  out  W  located y; 0 when found=0.
- steps  out  4  number of accepted verdicts in the last or current search.

Behaviour:
- Reset (rst=1 at a clk edge, from any state):
  - state=IDLE; lo=0, hi=2^W-1.
  - probe_valid=0, busy=0, done=0, found=0, error=0, result=0, steps=0.
  - Reset mid-search abandons the search with no done pulse.
- States: IDLE, PROBE, SETTLE, DONE.
- IDLE, start=1:
  - lo<=0, hi<=2^W-1; found, error, result, steps cleared.
  - Next state PROBE. start in any other state is ignored.
- PROBE:
  - probe_valid=1, busy=1; probe held constant.
  - Waits for cmp_valid=1. A verdict is accepted in the cycle it arrives (zero-wait accept legal).
  - steps increments on each accepted verdict.
- Verdict decode, evaluated when accepted:
  - Exactly one of lt/eq/gt high is required; otherwise error<=1, next state DONE.
  - eq: result<=probe, found<=1, next state DONE.
  - lt: if probe==hi then error<=1, next DONE; else lo<=probe+1, next SETTLE.
  - gt: if probe==lo then error<=1, next DONE; else hi<=probe-1, next SETTLE.
  - lo/hi arithmetic never under- or overflows because of these guards.
- SETTLE:
  - One cycle with probe_valid=0, busy=1, so a registered comparator sees a fresh request.
  - Next state PROBE.
- DONE:
  - done=1 for exactly one cycle, busy=0, next state IDLE.
  - result, found, error, steps held until the next accepted start.
- Latency (zero-wait comparator): start to done = 2k+1 cycles, where k = steps.
- Invariants:
  - Honest comparator: found=1 with steps<=W+1, and error is never set.
  - cmp_valid outside PROBE is ignored.

Optional Feature:
- Macro: CMP_TIMEOUT_EN.
- Defined:
  - A per-probe wait counter clears on entering PROBE.
  - If cmp_valid has not been seen after TIMEOUT cycles in PROBE: error<=1, found<=0, next state DONE.
  - steps is not incremented for the timed-out probe.
- Undefined: no counter; PROBE waits for cmp_valid indefinitely.

Test Plan:
- W=4, y=11, zero-wait comparator → probes 7 (lt), 11 (eq); found=1, result=11, steps=2, done 5 cycles after start.
- y=0 → probes 7, 3, 1, 0; found=1, result=0, steps=4. y=15 → probes 7, 11, 13, 14, 15; found=1, steps=5, no error.
- Comparator stuck at lt → probes 7, 11, 13, 14, 15; lt at probe 15 → error=1, found=0, result=0, steps=5. Verdict lt=gt=1 on the first probe → error=1, steps=1.
- cmp_valid delayed 3 cycles per probe, y=5 → probe and probe_valid stable while waiting, probe_valid low one cycle between probes; found=1, result=5. A cmp_valid pulse in IDLE and in SETTLE is ignored.
- rst asserted in PROBE on the second probe → next cycle all outputs are at reset values and no done pulse occurs. A following start with y=9 completes normally.
- With CMP_TIMEOUT_EN, TIMEOUT=15, cmp_valid never asserted → error=1 and done after 15 PROBE cycles. Without the macro → busy stays 1 indefinitely (check 100 cycles).
